// File: rtl/addsub_arbiter.sv
// Two-requester 8-bit add/sub unit with a three-state IDLE/CALC/RESP sequencer.
// Define ADDSUB_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module addsub_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_sub,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_sub,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_soma,
  output logic       rsp_cout,
  output logic       rsp_ovf,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t     state, state_nx;
  logic       grant_any;
  logic       grant_id;
  logic [7:0] a_q, b_q;
  logic       sub_q;
  logic [7:0] b_eff;
  logic [8:0] sum;
  logic       ovf;

  assign grant_any = req0_valid | req1_valid;

`ifdef ADDSUB_ARB_RR_EN
  // Requester that wins a tie; it is always the one not granted last.
  logic ptr;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ptr;
    else if (req1_valid)          grant_id = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          ptr <= 1'b0;
    else if (state == IDLE && grant_any) ptr <= ~grant_id;
  end
`else
  always_comb begin
    grant_id = ~req0_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = CALC;
      CALC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    if (rst_n && state == IDLE && grant_any) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
    if (state == RESP) rsp_valid = 1'b1;
  end

  // Subtraction is a + ~b + 1, so the carry-in is the sub flag itself.
  always_comb begin
    b_eff = sub_q ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {8'd0, sub_q};
    ovf   = (a_q[7] == b_eff[7]) && (sum[7] != a_q[7]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_soma <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_q    <= grant_id ? req1_a   : req0_a;
            b_q    <= grant_id ? req1_b   : req0_b;
            sub_q  <= grant_id ? req1_sub : req0_sub;
            rsp_id <= grant_id;
          end
        end
        CALC: begin
          rsp_soma <= sum[7:0];
          rsp_cout <= sum[8];
          rsp_ovf  <= ovf;
        end
        RESP: begin
          if (rsp_ready) ops_done <= ops_done + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
